// File: rtl/hazard_scoreboard_pkg.sv
// Shared widths and priority-match types for the hazard scoreboard.
// Also carries the `W_REGF/`W_DATA width macros.
`ifndef HAZARD_SCOREBOARD_DEFINES
`define HAZARD_SCOREBOARD_DEFINES
`define W_REGF 5
`define W_DATA 32
`endif

package hazard_scoreboard_pkg;
  localparam int REGW_DEF  = `W_REGF;
  localparam int DATAW_DEF = `W_DATA;
  localparam int IDX_W     = 4;

  typedef logic [IDX_W-1:0] fwd_idx_t;

  typedef struct packed {
    logic     found;
    logic     rdy;
    fwd_idx_t idx;
  } match_t;
endpackage

// File: rtl/fwd_match.sv
// Youngest-first priority search of one source over stages LO..NUM_FWD-1.
// Ports: src, regf/data/ready per stage -> m (match info), hit, hit_data.
module fwd_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int LO      = 0,
  parameter int REGW    = REGW_DEF,
  parameter int DATAW   = DATAW_DEF
) (
  input  logic [REGW-1:0]                src,
  input  logic [NUM_FWD-1:0][REGW-1:0]   regf,
  input  logic [NUM_FWD-1:0][DATAW-1:0]  data,
  input  logic [NUM_FWD-1:0]             ready,
  output match_t                         m,
  output logic                           hit,
  output logic [DATAW-1:0]               hit_data
);

  logic [DATAW-1:0] d;

  // Scan oldest to youngest so the youngest match is the last one kept.
  always_comb begin
    m = '0;
    d = '0;
    for (int k = NUM_FWD - 1; k >= LO; k--) begin
      if (src != '0 && regf[k] == src) begin
        m.found = 1'b1;
        m.rdy   = ready[k];
        m.idx   = fwd_idx_t'(k);
        d       = data[k];
      end
    end
    hit      = m.found & m.rdy;
    hit_data = hit ? d : '0;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Operand forwarding, load-use/branch stall and long-latency scoreboard.
// Ports: ID/EX sources, per-stage fwd info, lw issue/done -> stall, fwd, sb.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 3,
  parameter int JB_DEPTH = 2,
  parameter int REGW     = REGW_DEF,
  parameter int DATAW    = DATAW_DEF
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           id_valid,
  input  logic                           id_is_jb,
  input  logic [NUM_SRC-1:0][REGW-1:0]   id_src,
  input  logic [NUM_SRC-1:0][REGW-1:0]   ex_src,
  input  logic [NUM_FWD-1:0][REGW-1:0]   fwd_regf,
  input  logic [NUM_FWD-1:0][DATAW-1:0]  fwd_data,
  input  logic [NUM_FWD-1:0]             fwd_ready,
  input  logic                           lw_issue,
  input  logic [REGW-1:0]                lw_regf,
  input  logic                           lw_done,
  input  logic [REGW-1:0]                lw_done_regf,
  output logic                           stall,
  output logic [NUM_SRC-1:0]             fwd_id_hit,
  output logic [NUM_SRC-1:0][DATAW-1:0]  fwd_id_data,
  output logic [NUM_SRC-1:0]             fwd_ex_hit,
  output logic [NUM_SRC-1:0][DATAW-1:0]  fwd_ex_data,
  output logic                           sb_busy,
  output logic                           sb_err,
  output logic [31:0]                    stall_cnt
);

  localparam int NREG = 2 ** REGW;

  match_t               id_m [NUM_SRC];
  match_t               ex_m [NUM_SRC];
  logic   [NREG-1:0]    sb_q, sb_d;
  logic                 err_q, err_d;
  logic   [31:0]        stall_cnt_q;
  logic   [NUM_SRC-1:0] src_stall;
  logic                 set_v, clr_v;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(
      .NUM_FWD(NUM_FWD), .LO(0), .REGW(REGW), .DATAW(DATAW)
    ) u_id (
      .src(id_src[i]), .regf(fwd_regf), .data(fwd_data),
      .ready(fwd_ready), .m(id_m[i]),
      .hit(fwd_id_hit[i]), .hit_data(fwd_id_data[i])
    );
    fwd_match #(
      .NUM_FWD(NUM_FWD), .LO(1), .REGW(REGW), .DATAW(DATAW)
    ) u_ex (
      .src(ex_src[i]), .regf(fwd_regf), .data(fwd_data),
      .ready(fwd_ready), .m(ex_m[i]),
      .hit(fwd_ex_hit[i]), .hit_data(fwd_ex_data[i])
    );
  end

  // Scoreboard bit of r0 is never set, so (c) cannot fire for r0.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_stall[i] =
        (id_m[i].found & ~id_m[i].rdy) |
        (id_is_jb & id_m[i].found & (int'(id_m[i].idx) < JB_DEPTH)) |
        (sb_q[id_src[i]] & ~fwd_id_hit[i]);
    end
  end

  assign stall = resetn & id_valid & (|src_stall);

  assign set_v = lw_issue & (lw_regf != '0);
  assign clr_v = lw_done & (lw_done_regf != '0);

  // Clear first, then set: a same-register issue/done pair ends set.
  always_comb begin
    sb_d = sb_q;
    if (clr_v) sb_d[lw_done_regf] = 1'b0;
    if (set_v) sb_d[lw_regf] = 1'b1;
    err_d = err_q |
            (set_v & sb_q[lw_regf]) |
            (clr_v & ~sb_q[lw_done_regf]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_q        <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      err_q <= err_d;
      if (stall && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign sb_busy   = |sb_q;
  assign sb_err    = err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
// Drives on negedge, checks comb #1 later and state after edges.
module tb_hazard_scoreboard;

  logic             clk = 1'b0;
  logic             resetn;
  logic             id_valid, id_is_jb;
  logic [1:0][4:0]  id_src, ex_src;
  logic [2:0][4:0]  fwd_regf;
  logic [2:0][31:0] fwd_data;
  logic [2:0]       fwd_ready;
  logic             lw_issue, lw_done;
  logic [4:0]       lw_regf, lw_done_regf;
  logic             stall, sb_busy, sb_err;
  logic [1:0]       fwd_id_hit, fwd_ex_hit;
  logic [1:0][31:0] fwd_id_data, fwd_ex_data;
  logic [31:0]      stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .resetn(resetn),
    .id_valid(id_valid), .id_is_jb(id_is_jb),
    .id_src(id_src), .ex_src(ex_src),
    .fwd_regf(fwd_regf), .fwd_data(fwd_data),
    .fwd_ready(fwd_ready),
    .lw_issue(lw_issue), .lw_regf(lw_regf),
    .lw_done(lw_done), .lw_done_regf(lw_done_regf),
    .stall(stall),
    .fwd_id_hit(fwd_id_hit), .fwd_id_data(fwd_id_data),
    .fwd_ex_hit(fwd_ex_hit), .fwd_ex_data(fwd_ex_data),
    .sb_busy(sb_busy), .sb_err(sb_err),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_fwd();
    fwd_regf  = '0;
    fwd_data  = '0;
    fwd_ready = '0;
  endtask

  initial begin
    resetn = 1'b0;
    id_valid = 1'b1; id_is_jb = 1'b0;
    id_src = '0; ex_src = '0;
    clr_fwd();
    lw_issue = 1'b0; lw_regf = '0;
    lw_done = 1'b0; lw_done_regf = '0;

    // Reset: state clear, stall forced low, forwarding still live
    @(negedge clk);
    fwd_regf[0] = 5'd6; fwd_ready[0] = 1'b0;
    fwd_regf[1] = 5'd7; fwd_ready[1] = 1'b1;
    fwd_data[1] = 32'h77;
    id_src[0] = 5'd6; id_src[1] = 5'd7;
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_busy", 64'(sb_busy), 64'd0);
    check("rst_err", 64'(sb_err), 64'd0);
    check("rst_cnt", 64'(stall_cnt), 64'd0);
    check("rst_fwd", 64'(fwd_id_data[1]), 64'h77);
    @(negedge clk);
    resetn = 1'b1;
    id_valid = 1'b0;
    clr_fwd();
    id_src = '0;
    tick();

    // ALU chain, plus EX skipping stage 0
    id_valid = 1'b1;
    fwd_regf[0] = 5'd5; fwd_ready[0] = 1'b1;
    fwd_data[0] = 32'h11;
    fwd_regf[1] = 5'd5; fwd_ready[1] = 1'b1;
    fwd_data[1] = 32'h22;
    id_src[0] = 5'd5; ex_src[0] = 5'd5;
    #1;
    check("alu_hit", 64'(fwd_id_hit[0]), 64'd1);
    check("alu_data", 64'(fwd_id_data[0]), 64'h11);
    check("alu_stall", 64'(stall), 64'd0);
    check("ex_youngest", 64'(fwd_ex_data[0]), 64'h22);
    check("ex_hit", 64'(fwd_ex_hit[0]), 64'd1);

    // Load-use
    @(negedge clk);
    clr_fwd();
    id_src = '0; ex_src = '0;
    fwd_regf[0] = 5'd8; fwd_ready[0] = 1'b0;
    fwd_data[0] = 32'hDEAD;
    id_src[1] = 5'd8;
    #1;
    check("lu_stall", 64'(stall), 64'd1);
    check("lu_nohit", 64'(fwd_id_hit[1]), 64'd0);
    check("lu_zero", 64'(fwd_id_data[1]), 64'd0);
    tick();
    check("lu_cnt", 64'(stall_cnt), 64'd1);
    clr_fwd();
    fwd_regf[1] = 5'd8; fwd_ready[1] = 1'b1;
    fwd_data[1] = 32'h33;
    #1;
    check("lu_go", 64'(stall), 64'd0);
    check("lu_data", 64'(fwd_id_data[1]), 64'h33);

    // Branch: stage 1 too young, stage 2 usable
    @(negedge clk);
    clr_fwd();
    id_src = '0;
    id_is_jb = 1'b1;
    fwd_regf[1] = 5'd3; fwd_ready[1] = 1'b1;
    fwd_data[1] = 32'h44;
    id_src[0] = 5'd3;
    #1;
    check("jb_stall", 64'(stall), 64'd1);
    tick();
    check("jb_cnt", 64'(stall_cnt), 64'd2);
    clr_fwd();
    fwd_regf[2] = 5'd3; fwd_ready[2] = 1'b1;
    fwd_data[2] = 32'h55;
    #1;
    check("jb_go", 64'(stall), 64'd0);
    check("jb_data", 64'(fwd_id_data[0]), 64'h55);

    // Scoreboard on r9
    @(negedge clk);
    clr_fwd();
    id_is_jb = 1'b0;
    id_src = '0;
    id_src[0] = 5'd9;
    lw_issue = 1'b1; lw_regf = 5'd9;
    #1;
    check("sb_pre", 64'(stall), 64'd0);
    tick();
    lw_issue = 1'b0;
    #1;
    check("sb_busy", 64'(sb_busy), 64'd1);
    check("sb_stall", 64'(stall), 64'd1);
    tick();
    lw_done = 1'b1; lw_done_regf = 5'd9;
    #1;
    check("sb_done_cyc", 64'(stall), 64'd1);
    tick();
    lw_done = 1'b0;
    #1;
    check("sb_drop", 64'(stall), 64'd0);
    check("sb_idle", 64'(sb_busy), 64'd0);
    check("sb_noerr", 64'(sb_err), 64'd0);
    check("sb_cnt", 64'(stall_cnt), 64'd4);

    // Ready forward overrides a pending bit
    id_valid = 1'b0;
    lw_issue = 1'b1; lw_regf = 5'd9;
    tick();
    lw_issue = 1'b0;
    id_valid = 1'b1;
    fwd_regf[2] = 5'd9; fwd_ready[2] = 1'b1;
    fwd_data[2] = 32'h99;
    #1;
    check("sb_fwd_ok", 64'(stall), 64'd0);
    check("sb_fwd_data", 64'(fwd_id_data[0]), 64'h99);

    // Error: done on clear r4
    @(negedge clk);
    clr_fwd();
    id_valid = 1'b0;
    lw_done = 1'b1; lw_done_regf = 5'd4;
    tick();
    lw_done = 1'b0;
    #1;
    check("err_set", 64'(sb_err), 64'd1);
    check("err_keep9", 64'(sb_busy), 64'd1);

    // Simultaneous issue and done on r9: bit stays set
    @(negedge clk);
    lw_issue = 1'b1; lw_regf = 5'd9;
    lw_done = 1'b1; lw_done_regf = 5'd9;
    tick();
    lw_issue = 1'b0; lw_done = 1'b0;
    id_valid = 1'b1;
    #1;
    check("sim_busy", 64'(sb_busy), 64'd1);
    check("sim_stall", 64'(stall), 64'd1);

    // Reset mid-pending (async, before next edge)
    #1;
    resetn = 1'b0;
    #1;
    check("mid_busy", 64'(sb_busy), 64'd0);
    check("mid_err", 64'(sb_err), 64'd0);
    check("mid_cnt", 64'(stall_cnt), 64'd0);
    check("mid_stall", 64'(stall), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("post_nostall", 64'(stall), 64'd0);
    id_valid = 1'b0;
    lw_done = 1'b1; lw_done_regf = 5'd9;
    tick();
    lw_done = 1'b0;
    #1;
    check("post_err", 64'(sb_err), 64'd1);

    // r0 never matches
    @(negedge clk);
    id_valid = 1'b1;
    id_is_jb = 1'b1;
    fwd_regf = '0;
    fwd_ready = 3'b011;
    fwd_data = {32'h3, 32'h2, 32'h1};
    id_src = '0; ex_src = '0;
    lw_issue = 1'b1; lw_regf = 5'd0;
    #1;
    check("r0_hit", 64'(fwd_id_hit), 64'd0);
    check("r0_exhit", 64'(fwd_ex_hit), 64'd0);
    check("r0_stall", 64'(stall), 64'd0);
    tick();
    lw_issue = 1'b0;
    #1;
    check("r0_sb", 64'(sb_busy), 64'd0);

    // Saturation from a preloaded count
    id_is_jb = 1'b0;
    clr_fwd();
    fwd_regf[0] = 5'd7; fwd_ready[0] = 1'b0;
    id_src[0] = 5'd7;
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    #1;
    check("sat_stall", 64'(stall), 64'd1);
    tick();
    check("sat_fe", 64'(stall_cnt), 64'hFFFF_FFFE);
    tick();
    tick();
    tick();
    check("sat_max", 64'(stall_cnt), 64'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameters SHALL be: NUM_SRC (default 2), source operands per stage; NUM_FWD (default 3), forwarding stages, index 0 = EX, youngest first; JB_DEPTH (default 2), number of youngest stages a branch in ID cannot take data from; REGW (default 5), register index width; DATAW (default 32), data width.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_is_jb  in  1  ID instruction is a jump or branch.
- id_src  in  NUM_SRC x REGW  ID source registers.
- ex_src  in  NUM_SRC x REGW  EX source registers.
- fwd_regf  in  NUM_FWD x REGW  destination register per stage; 0 means none.
- fwd_data  in  NUM_FWD x DATAW  result per stage.
- fwd_ready  in  NUM_FWD  stage result is final this cycle.
- lw_issue  in  1  a long-latency writer (cache-miss load or MDU) is issued.
- lw_regf  in  REGW  destination of the issued long-latency writer.
- lw_done  in  1  a long-latency writer completes.
- lw_done_regf  in  REGW  destination of the completing writer.
- stall  out  1  hold IF/ID.
- fwd_id_hit  out  NUM_SRC  ID operand is forwarded.
- fwd_id_data  out  NUM_SRC x DATAW  forwarded ID operand.
- fwd_ex_hit  out  NUM_SRC  EX operand is forwarded.
- fwd_ex_data  out  NUM_SRC x DATAW  forwarded EX operand.
- sb_busy  out  1  at least one scoreboard bit is set.
- sb_err  out  1  sticky protocol error.
- stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-003 Register 0 SHALL never match: no forwarding, no stall, no scoreboard set.
REQ-004 For each ID source, the youngest stage k in 0..NUM_FWD-1 with fwd_regf[k]==src SHALL be the match.
- If that stage has fwd_ready[k]=1: fwd_id_hit=1 and fwd_id_data=fwd_data[k].
- Otherwise: hit=0 and data=0.
REQ-005 For each EX source, the same search SHALL run over stages 1..NUM_FWD-1 only.
REQ-006 Forwarding outputs SHALL be combinational, with zero-cycle latency.
REQ-007 stall SHALL be asserted when id_valid=1 and any ID source meets any of these conditions:
- (a) its youngest match has fwd_ready=0;
- (b) id_is_jb=1 and its youngest match index is below JB_DEPTH;
- (c) its scoreboard bit is set and no stage gives a ready match.
REQ-008 The scoreboard SHALL be a vector of 2^REGW bits.
- A bit is set on the edge after lw_issue.
- A bit is cleared on the edge after lw_done.
- It is read the cycle after update.
REQ-009 When lw_issue and lw_done name the same register in the same cycle, the bit SHALL end set (issue wins).
REQ-010 lw_done on a clear bit, or lw_issue on an already-set bit, SHALL leave the vector unchanged apart from REQ-009 and SHALL set sb_err; sb_err is cleared only by reset.
REQ-011 sb_busy SHALL be the OR of all scoreboard bits, registered view.
REQ-012 stall_cnt SHALL increment on each clock edge where stall=1 and saturate at 0xFFFFFFFF.
REQ-013 stall SHALL depend only on current inputs and registered state, with no combinational path from stall to itself.

Reset
REQ-014 While resetn=0, the following SHALL be cleared asynchronously: scoreboard, sb_busy, sb_err, stall_cnt.
REQ-015 Reset mid-operation SHALL drop all pending scoreboard bits; a lw_done after reset sets sb_err.
REQ-016 Combinational outputs SHALL follow their inputs during reset, except that stall is forced to 0.

Structure
REQ-017 The shared package SHALL hold the REGW/DATAW defaults and the priority-match function typedefs; the defines header keeps the `W_REGF/`W_DATA widths.
REQ-018 One sub-module, fwd_match (a priority search over NUM_FWD stages for one source), SHALL be instantiated per ID and EX source.

Verification
REQ-019 Directed scenarios:
- ALU chain: fwd_regf[0]=5, ready, data 0x11; id_src[0]=5 -> fwd_id_hit[0]=1, data 0x11, stall=0.
- Load-use: fwd_regf[0]=8, fwd_ready[0]=0, id_src[1]=8 -> stall=1; next cycle the match is at stage 1 with ready=1 -> stall=0, hit.
- Branch: id_is_jb=1, stage 1 writes r3 ready, id_src[0]=3 -> stall=1; r3 at stage 2 -> stall=0, forward from stage 2.
- Scoreboard: lw_issue r9; following cycles id_src=9 -> stall=1, sb_busy=1; lw_done r9 -> stall drops one cycle later; simultaneous issue and done on r9 -> bit stays set.
- Error and reset: lw_done r4 with clear bit -> sb_err=1; resetn=0 mid-pending -> sb_busy=0, sb_err=0, stall_cnt=0.
- r0 and saturation: all stages write r0, id_src=0 -> no hit, no stall; stall held with stall_cnt preloaded near max -> stall_cnt stays 0xFFFFFFFF.
